uib_lsu_master: RTL and testbench
=================================

Name: uib_lsu_master

Overview:
- Load/store bus master that sits directly upstream of the main memory slave on the UIB bus.
- Accepts one CPU load/store request at a time over a valid/ready handshake.
- Checks alignment, drives one registered UIB access with the size mode and lane-positioned write data, waits the slave's fixed read latency, then returns extracted, sign- or zero-extended load data with a one-cycle response pulse.

Parameters:
- XLEN, 32, data width of the CPU side and of the bus.
- ADDR_WIDTH, 32, byte-address width.
- RD_LAT, 1, cycles from the bus_req cycle to valid bus_dat_i; legal range 1..4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- cpu_valid  in  1  request present.
- cpu_ready  out  1  block can accept a request.
- cpu_wen  in  1  1 = store, 0 = load.
- cpu_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- cpu_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  XLEN  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned access or reserved size; valid only with rsp_valid.
- bus_req  out  1  UIB access strobe.
- bus_wen  out  1  UIB write enable.
- bus_mode  out  2  UIB size mode; same encoding as cpu_size.
- bus_addr  out  ADDR_WIDTH  UIB byte address.
- bus_dat_o  out  XLEN  UIB write data, lane-positioned.
- bus_dat_i  in  XLEN  UIB read data, full word; disabled lanes read 0.

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. Every output is registered.
- Reset values: state IDLE, cpu_ready=1, and every other output 0.
- IDLE:
  - cpu_ready=1 only in this state.
  - A transfer occurs on a rising edge with cpu_valid=1; address, size, wen, unsigned and wdata are latched at that edge.
- Alignment check at acceptance:
  - Half requires addr[0]=0; word requires addr[1:0]=0.
  - Size 11 is always an error.
  - On error: go to DONE with no bus access; rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle.
- ISSUE, exactly one cycle:
  - bus_req=1, bus_wen=wen, bus_addr=latched addr, bus_mode=size.
  - bus_dat_o for a byte store: wdata[7:0] << 8*addr[1:0].
  - bus_dat_o for a half store: wdata[15:0] << 16*addr[1].
  - bus_dat_o for a word store: wdata unchanged.
  - Loads drive bus_dat_o=0.
- Outside ISSUE: bus_req=0, bus_wen=0, and bus_addr, bus_mode, bus_dat_o all 0.
- Stores: ISSUE goes to DONE; rsp_valid is high 2 cycles after the acceptance edge.
- Loads:
  - ISSUE goes to WAIT; a counter runs RD_LAT-1 further cycles.
  - bus_dat_i is sampled only in the cycle RD_LAT after the bus_req cycle and ignored in all other cycles.
  - Lane extraction: byte = bus_dat_i >> 8*addr[1:0], bits [7:0]; half = bus_dat_i >> 16*addr[1], bits [15:0].
  - The extracted value is extended per cpu_unsigned.
  - rsp_valid is high in the cycle after the sample: cycle 2+RD_LAT after acceptance, which is 3 for the default.
- DONE:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - cpu_ready rises in the cycle after rsp_valid, so the minimum spacing between back-to-back accesses is that cycle.
  - rsp_rdata and rsp_err return to 0 after the pulse.
- cpu_valid while not ready is ignored, and inputs may change freely then.
- Reset mid-operation, any state:
  - All outputs clear immediately and asynchronously, including bus_req.
  - The in-flight request is dropped and no rsp_valid is produced.
  - cpu_ready=1 after release.

Test Plan:
- Word store 0xDEADBEEF to 0x10, then word load from 0x10, with bus model returning 0xDEADBEEF at RD_LAT=1:
  - Store: bus_req high for 1 cycle with bus_wen=1, bus_mode=10.
  - Load: rsp_rdata=0xDEADBEEF with rsp_valid in cycle 3 after acceptance.
- Byte loads from 0x13, bus_dat_i=0x80112233:
  - cpu_unsigned=0 gives rsp_rdata=0xFFFFFF80.
  - cpu_unsigned=1 gives 0x00000080.
- Half store cpu_wdata=0x1234ABCD to 0x0E -> bus_mode=01, bus_addr=0x0E, bus_dat_o=0xABCD0000, rsp_valid in cycle 2, rsp_err=0.
- Misaligned accesses (error-path checks):
  - Half load at 0x01 -> no bus_req ever; rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle 1.
  - Word store at 0x02 -> same response.
  - cpu_size=11 -> same response.
- RD_LAT=3, half signed load at 0x02:
  - bus_dat_i=0x8001FFFF in the sample cycle, garbage in all others.
  - Required: rsp_rdata=0xFFFF8001 with rsp_valid in cycle 5.
- Reset during WAIT:
  - Assert rst=0 mid-cycle -> bus outputs and rsp_valid go to 0 immediately and no response appears.
  - After release, cpu_ready=1, and a new word load completes normally.

Source files
------------

// File: rtl/uib_lsu_master.sv
// uib_lsu_master
//
// Load/store bus master placed directly in front of the main memory slave on
// the UIB bus. It accepts one CPU request at a time, rejects misaligned or
// reserved-size requests without touching the bus, otherwise issues a single
// one-cycle UIB access, waits the slave's fixed read latency for loads, and
// returns the extracted and extended load data with a one-cycle pulse.
//
// Handshake: a request transfers on a rising clk edge where cpu_valid=1 and
// cpu_ready=1. cpu_ready is high only while idle; cpu_valid and the request
// fields are ignored (and may change freely) whenever cpu_ready=0. There is no
// back-pressure on the response: rsp_valid is a single-cycle pulse.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active low
//   cpu_valid     request present
//   cpu_ready     request can be accepted (idle)
//   cpu_wen       1 = store, 0 = load
//   cpu_size      00 byte, 01 half, 10 word, 11 reserved
//   cpu_unsigned  load zero-extends when 1, sign-extends when 0
//   cpu_addr      byte address
//   cpu_wdata     store data, right-aligned
//   rsp_valid     one-cycle completion pulse
//   rsp_rdata     extended load data (0 for stores and errors)
//   rsp_err       misaligned access or reserved size
//   bus_req       UIB access strobe (one cycle per access)
//   bus_wen       UIB write enable
//   bus_mode      UIB size mode, same encoding as cpu_size
//   bus_addr      UIB byte address
//   bus_dat_o     UIB write data, positioned on the addressed lanes
//   bus_dat_i     UIB read data, full word, disabled lanes read 0
//   dbg_state     current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 DONE)

module uib_lsu_master #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_valid,
    output logic                  cpu_ready,
    input  logic                  cpu_wen,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [XLEN-1:0]       cpu_wdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_err,
    output logic                  bus_req,
    output logic                  bus_wen,
    output logic [1:0]            bus_mode,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [XLEN-1:0]       bus_dat_o,
    input  logic [XLEN-1:0]       bus_dat_i,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] RD_LAT_CNT = 3'(RD_LAT);

    state_t      state;
    logic [1:0]  addr_lo_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        wen_q;
    logic [2:0]  wait_cnt;

    logic            req_err;
    logic [XLEN-1:0] wdata_lane;
    logic [XLEN-1:0] rd_shift;
    logic [XLEN-1:0] load_ext;

    assign dbg_state = state;

    // Alignment / size legality of the request currently offered.
    always_comb begin
        req_err = 1'b0;
        case (cpu_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = cpu_addr[0];
            2'b10:   req_err = |cpu_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Store data moved onto the byte lanes selected by the low address bits.
    // Computed from the live request so it can be registered at acceptance.
    always_comb begin
        wdata_lane = '0;
        if (cpu_wen) begin
            case (cpu_size)
                2'b00:   wdata_lane = XLEN'(cpu_wdata[7:0]) << {cpu_addr[1:0], 3'b000};
                2'b01:   wdata_lane = XLEN'(cpu_wdata[15:0]) << {cpu_addr[1], 4'b0000};
                default: wdata_lane = cpu_wdata;
            endcase
        end
    end

    // Load lane extraction and extension from the latched request fields.
    always_comb begin
        rd_shift = bus_dat_i >> {addr_lo_q, 3'b000};
        load_ext = bus_dat_i;
        case (size_q)
            2'b00: load_ext = uns_q ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
                                    : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
            2'b01: load_ext = uns_q ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
                                    : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
            default: load_ext = bus_dat_i;
        endcase
    end

    // All outputs are registered; each is set on the edge that enters the
    // state in which it must be visible, and cleared on the edge that leaves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cpu_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_mode  <= '0;
            bus_addr  <= '0;
            bus_dat_o <= '0;
            addr_lo_q <= '0;
            size_q    <= '0;
            uns_q     <= 1'b0;
            wen_q     <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_valid) begin
                        addr_lo_q <= cpu_addr[1:0];
                        size_q    <= cpu_size;
                        uns_q     <= cpu_unsigned;
                        wen_q     <= cpu_wen;
                        cpu_ready <= 1'b0;
                        if (req_err) begin
                            // Rejected: respond next cycle, never touch the bus.
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state     <= S_ISSUE;
                            bus_req   <= 1'b1;
                            bus_wen   <= cpu_wen;
                            bus_mode  <= cpu_size;
                            bus_addr  <= cpu_addr;
                            bus_dat_o <= wdata_lane;
                        end
                    end
                end
                S_ISSUE: begin
                    bus_req   <= 1'b0;
                    bus_wen   <= 1'b0;
                    bus_mode  <= '0;
                    bus_addr  <= '0;
                    bus_dat_o <= '0;
                    if (wen_q) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        // First WAIT cycle is already RD_LAT=1 after bus_req.
                        state    <= S_WAIT;
                        wait_cnt <= 3'd1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == RD_LAT_CNT) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= load_ext;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cpu_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uib_lsu_master.sv
// Bench for uib_lsu_master: one instance at RD_LAT=1 and one at RD_LAT=3,
// each in front of its own word-wide slave model. Expected results come from a
// byte-addressed reference memory per instance and the access rules.
module tb_uib_lsu_master;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Shared request fields, per-instance valid.
  logic        v1 = 1'b0, v3 = 1'b0;
  logic        cpu_wen = 1'b0, cpu_unsigned = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;

  logic        ready1, rv1, re1, breq1, bwen1;
  logic [31:0] rd1, baddr1, bdo1, bdi1;
  logic [1:0]  bmode1, dbg1;
  logic        ready3, rv3, re3, breq3, bwen3;
  logic [31:0] rd3, baddr3, bdo3, bdi3;
  logic [1:0]  bmode3, dbg3;

  uib_lsu_master #(.XLEN(32), .ADDR_WIDTH(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .cpu_valid(v1), .cpu_ready(ready1), .cpu_wen(cpu_wen),
    .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1),
    .bus_req(breq1), .bus_wen(bwen1), .bus_mode(bmode1), .bus_addr(baddr1),
    .bus_dat_o(bdo1), .bus_dat_i(bdi1), .dbg_state(dbg1)
  );

  uib_lsu_master #(.XLEN(32), .ADDR_WIDTH(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cpu_valid(v3), .cpu_ready(ready3), .cpu_wen(cpu_wen),
    .cpu_size(cpu_size), .cpu_unsigned(cpu_unsigned), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3),
    .bus_req(breq3), .bus_wen(bwen3), .bus_mode(bmode3), .bus_addr(baddr3),
    .bus_dat_o(bdo3), .bus_dat_i(bdi3), .dbg_state(dbg3)
  );

  // Selected-instance view used by the driver.
  int sel = 1;
  logic        s_ready, s_rv, s_re, s_breq, s_bwen;
  logic [31:0] s_rd, s_baddr, s_bdo;
  logic [1:0]  s_bmode;
  assign s_ready = (sel == 3) ? ready3 : ready1;
  assign s_rv    = (sel == 3) ? rv3    : rv1;
  assign s_re    = (sel == 3) ? re3    : re1;
  assign s_rd    = (sel == 3) ? rd3    : rd1;
  assign s_breq  = (sel == 3) ? breq3  : breq1;
  assign s_bwen  = (sel == 3) ? bwen3  : bwen1;
  assign s_baddr = (sel == 3) ? baddr3 : baddr1;
  assign s_bdo   = (sel == 3) ? bdo3   : bdo1;
  assign s_bmode = (sel == 3) ? bmode3 : bmode1;

  // Slave word memories (index 0 -> RD_LAT=1 instance, 1 -> RD_LAT=3) and
  // byte-addressed reference memories.
  logic [31:0] smem [0:1][0:63];
  logic [7:0]  rmem [0:1][0:255];

  function automatic logic [31:0] lane_mask(input logic [1:0] mode, input logic [31:0] a);
    logic [31:0] m;
    case (mode)
      2'b00:   m = 32'h0000_00FF << (a[1:0] * 8);
      2'b01:   m = 32'h0000_FFFF << (a[1] * 16);
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Slave models: read data valid exactly RD_LAT cycles after the bus_req
  // cycle, random garbage in every other cycle. Driven on the falling edge.
  logic [4:0]  h1_req = '0, h3_req = '0;
  logic [31:0] h1_addr [0:4], h3_addr [0:4];
  logic [1:0]  h1_mode [0:4], h3_mode [0:4];

  always @(negedge clk) begin
    logic [31:0] m;
    for (int i = 4; i > 0; i--) begin
      h1_addr[i] = h1_addr[i-1]; h1_mode[i] = h1_mode[i-1];
      h3_addr[i] = h3_addr[i-1]; h3_mode[i] = h3_mode[i-1];
    end
    h1_req = {h1_req[3:0], breq1};  h1_addr[0] = baddr1; h1_mode[0] = bmode1;
    h3_req = {h3_req[3:0], breq3};  h3_addr[0] = baddr3; h3_mode[0] = bmode3;
    if (breq1 && bwen1) begin
      m = lane_mask(bmode1, baddr1);
      smem[0][baddr1[7:2]] = (smem[0][baddr1[7:2]] & ~m) | (bdo1 & m);
    end
    if (breq3 && bwen3) begin
      m = lane_mask(bmode3, baddr3);
      smem[1][baddr3[7:2]] = (smem[1][baddr3[7:2]] & ~m) | (bdo3 & m);
    end
    if (h1_req[1]) bdi1 = smem[0][h1_addr[1][7:2]] & lane_mask(h1_mode[1], h1_addr[1]);
    else           bdi1 = $urandom;
    if (h3_req[3]) bdi3 = smem[1][h3_addr[3][7:2]] & lane_mask(h3_mode[3], h3_addr[3]);
    else           bdi3 = $urandom;
  end

  // ---------------- reference model ----------------
  function automatic int midx(input int inst);
    return (inst == 3) ? 1 : 0;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic exp_err(input logic [1:0] size, input logic [31:0] a);
    return (size == 2'b11) || (size == 2'b01 && (a % 2) != 0) || (size == 2'b10 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input int inst, input logic [1:0] size,
                                           input logic uns, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ones;
    int n;
    v = '0; ones = '1; n = nbytes(size);
    for (int k = 0; k < n; k++) v = v | (32'(rmem[midx(inst)][a[7:0] + 8'(k)]) << (8 * k));
    if (!uns && n < 4 && v[8*n-1]) v = v | (ones << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] exp_bus_dat(input logic wen, input logic [1:0] size,
                                              input logic [31:0] a, input logic [31:0] wd);
    if (!wen) return 32'h0;
    if (size == 2'b00) return (wd & 32'hFF) << (8 * (a % 4));
    if (size == 2'b01) return (wd & 32'hFFFF) << (8 * (a % 4));
    return wd;
  endfunction

  task automatic ref_store(input int inst, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd);
    for (int k = 0; k < nbytes(size); k++) rmem[midx(inst)][a[7:0] + 8'(k)] = wd[8*k +: 8];
  endtask

  task automatic poke(input int inst, input logic [31:0] a, input logic [31:0] w);
    smem[midx(inst)][a[7:2]] = w;
    for (int k = 0; k < 4; k++) rmem[midx(inst)][{a[7:2], 2'b00} + 8'(k)] = w[8*k +: 8];
  endtask

  // ---------------- driver ----------------
  task automatic set_valid(input logic v);
    if (sel == 3) v3 = v; else v1 = v;
  endtask

  task automatic scramble_req();
    cpu_wen = 1'($urandom); cpu_size = 2'($urandom); cpu_unsigned = 1'($urandom);
    cpu_addr = $urandom; cpu_wdata = $urandom;
  endtask

  task automatic accept(input int inst, input logic wen, input logic [1:0] size,
                        input logic uns, input logic [31:0] a, input logic [31:0] wd);
    int t;
    sel = inst; t = 0;
    @(negedge clk);
    while (!s_ready && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait inst=%0d cpu_ready=%b expected 1 within 20 cycles", inst, s_ready);
    end
    cpu_wen = wen; cpu_size = size; cpu_unsigned = uns; cpu_addr = a; cpu_wdata = wd;
    set_valid(1'b1);
    @(posedge clk);
    #1;
    set_valid(1'b0);
    scramble_req();
  endtask

  int          o_lat, o_pulses, o_nreq;
  logic        o_err, o_wen, o_busy_ready, o_rdy_after, o_clear_after;
  logic [31:0] o_rd, o_addr, o_dat;
  logic [1:0]  o_mode;

  // Accept one request, then watch 12 cycles (cycle 1 = first after the
  // acceptance edge) while offering ignored garbage requests until the pulse.
  task automatic run_txn(input int inst, input logic wen, input logic [1:0] size,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
    accept(inst, wen, size, uns, a, wd);
    o_lat = -1; o_pulses = 0; o_nreq = 0; o_err = 1'b0; o_rd = '0;
    o_wen = 1'b0; o_mode = '0; o_addr = '0; o_dat = '0;
    o_busy_ready = 1'b0; o_rdy_after = 1'b0; o_clear_after = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (s_breq) begin
        o_nreq++; o_wen = s_bwen; o_mode = s_bmode; o_addr = s_baddr; o_dat = s_bdo;
      end
      if (o_lat > 0 && c == o_lat + 1) begin
        o_rdy_after = s_ready;
        o_clear_after = (s_rd === 32'h0) && (s_re === 1'b0);
      end
      if (s_rv) begin
        o_pulses++;
        if (o_lat < 0) begin o_lat = c; o_rd = s_rd; o_err = s_re; end
      end
      if ((o_lat < 0 || o_lat == c) && s_ready) o_busy_ready = 1'b1;
      if (o_lat < 0) begin scramble_req(); set_valid(1'($urandom)); end
      else set_valid(1'b0);
    end
    set_valid(1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b expected 1/1", ready1, ready3);
    end
    checks++;
    if ({rv1, re1, breq1, bwen1, bmode1, dbg1} !== 7'b0 || rd1 !== 0 || baddr1 !== 0 || bdo1 !== 0) begin
      errors++; $display("FAIL reset_outputs rv=%b err=%b req=%b wen=%b mode=%b st=%0d rd=%h addr=%h dat=%h expected all 0",
                         rv1, re1, breq1, bwen1, bmode1, dbg1, rd1, baddr1, bdo1);
    end
    rst = 1'b1;
  endtask

  task automatic test_word_store_load();
    run_txn(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    ref_store(1, 2'b10, 32'h10, 32'hDEADBEEF);
    checks++;
    if (o_nreq !== 1 || o_wen !== 1'b1 || o_mode !== 2'b10 || o_addr !== 32'h10 || o_dat !== 32'hDEADBEEF) begin
      errors++; $display("FAIL word_store_bus nreq=%0d wen=%b mode=%b addr=%h dat=%h expected 1 1 10 00000010 deadbeef",
                         o_nreq, o_wen, o_mode, o_addr, o_dat);
    end
    checks++;
    if (o_lat !== 2 || o_err !== 1'b0 || o_rd !== 32'h0) begin
      errors++; $display("FAIL word_store_rsp lat=%0d err=%b rd=%h expected 2 0 0", o_lat, o_err, o_rd);
    end
    run_txn(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (o_lat !== 3 || o_rd !== 32'hDEADBEEF || o_pulses !== 1 || o_dat !== 32'h0) begin
      errors++; $display("FAIL word_load lat=%0d rd=%h pulses=%0d busdat=%h expected 3 deadbeef 1 0",
                         o_lat, o_rd, o_pulses, o_dat);
    end
    checks++;
    if (o_busy_ready !== 1'b0 || o_rdy_after !== 1'b1 || o_clear_after !== 1'b1) begin
      errors++; $display("FAIL word_load_ready busy_ready=%b ready_after=%b cleared=%b expected 0 1 1",
                         o_busy_ready, o_rdy_after, o_clear_after);
    end
  endtask

  task automatic test_byte_loads();
    poke(1, 32'h10, 32'h80112233);
    run_txn(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    checks++;
    if (o_rd !== 32'hFFFFFF80 || o_lat !== 3 || o_mode !== 2'b00 || o_addr !== 32'h13) begin
      errors++; $display("FAIL byte_load_signed rd=%h lat=%0d mode=%b addr=%h expected ffffff80 3 00 00000013",
                         o_rd, o_lat, o_mode, o_addr);
    end
    run_txn(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++;
    if (o_rd !== 32'h00000080 || o_lat !== 3) begin
      errors++; $display("FAIL byte_load_unsigned rd=%h lat=%0d expected 00000080 3", o_rd, o_lat);
    end
  endtask

  task automatic test_half_store();
    run_txn(1, 1'b1, 2'b01, 1'b0, 32'h0E, 32'h1234ABCD);
    ref_store(1, 2'b01, 32'h0E, 32'h1234ABCD);
    checks++;
    if (o_mode !== 2'b01 || o_addr !== 32'h0E || o_dat !== 32'hABCD0000 || o_wen !== 1'b1) begin
      errors++; $display("FAIL half_store_bus mode=%b addr=%h dat=%h wen=%b expected 01 0000000e abcd0000 1",
                         o_mode, o_addr, o_dat, o_wen);
    end
    checks++;
    if (o_lat !== 2 || o_err !== 1'b0) begin
      errors++; $display("FAIL half_store_rsp lat=%0d err=%b expected 2 0", o_lat, o_err);
    end
  endtask

  task automatic test_misaligned();
    logic        wen [0:2];
    logic [1:0]  sz  [0:2];
    logic [31:0] ad  [0:2];
    wen[0] = 1'b0; sz[0] = 2'b01; ad[0] = 32'h01;
    wen[1] = 1'b1; sz[1] = 2'b10; ad[1] = 32'h02;
    wen[2] = 1'b0; sz[2] = 2'b11; ad[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      run_txn(1, wen[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF);
      checks++;
      if (o_nreq !== 0 || o_lat !== 1 || o_err !== 1'b1 || o_rd !== 32'h0 || o_pulses !== 1) begin
        errors++; $display("FAIL misaligned_%0d nreq=%0d lat=%0d err=%b rd=%h pulses=%0d expected 0 1 1 0 1",
                           i, o_nreq, o_lat, o_err, o_rd, o_pulses);
      end
    end
  endtask

  task automatic test_rdlat3();
    poke(3, 32'h00, 32'h8001FFFF);
    run_txn(3, 1'b0, 2'b01, 1'b0, 32'h02, 32'h0);
    checks++;
    if (o_rd !== 32'hFFFF8001 || o_lat !== 5 || o_pulses !== 1 || o_nreq !== 1) begin
      errors++; $display("FAIL rdlat3_half rd=%h lat=%0d pulses=%0d nreq=%0d expected ffff8001 5 1 1",
                         o_rd, o_lat, o_pulses, o_nreq);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    logic [31:0] exp;
    // Reset while bus_req is high (ISSUE).
    accept(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    #3;
    checks++;
    if (breq1 !== 1'b1) begin errors++; $display("FAIL issue_before_reset bus_req=%b expected 1", breq1); end
    rst = 1'b0;
    #1;
    checks++;
    if (breq1 !== 1'b0 || baddr1 !== 0 || bmode1 !== 0 || ready1 !== 1'b1 || dbg1 !== 2'd0) begin
      errors++; $display("FAIL reset_issue req=%b addr=%h mode=%b ready=%b st=%0d expected 0 0 0 1 0",
                         breq1, baddr1, bmode1, ready1, dbg1);
    end
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (rv1) pulses++; end
    checks++;
    if (pulses !== 0 || ready1 !== 1'b1) begin
      errors++; $display("FAIL reset_issue_after pulses=%0d ready=%b expected 0 1", pulses, ready1);
    end
    // Reset during WAIT on the RD_LAT=3 instance.
    accept(3, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    @(posedge clk);
    #3;
    checks++;
    if (dbg3 !== 2'd2) begin errors++; $display("FAIL wait_before_reset state=%0d expected 2", dbg3); end
    rst = 1'b0;
    #1;
    checks++;
    if (rv3 !== 1'b0 || breq3 !== 1'b0 || rd3 !== 0 || ready3 !== 1'b1) begin
      errors++; $display("FAIL reset_wait rv=%b req=%b rd=%h ready=%b expected 0 0 0 1", rv3, breq3, rd3, ready3);
    end
    @(negedge clk); rst = 1'b1;
    pulses = 0;
    repeat (8) begin @(negedge clk); if (rv3) pulses++; end
    checks++;
    if (pulses !== 0 || ready3 !== 1'b1) begin
      errors++; $display("FAIL reset_wait_after pulses=%0d ready=%b expected 0 1", pulses, ready3);
    end
    exp = ref_load(3, 2'b10, 1'b0, 32'h24);
    run_txn(3, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
    checks++;
    if (o_rd !== exp || o_lat !== 5 || o_err !== 1'b0) begin
      errors++; $display("FAIL load_after_reset rd=%h lat=%0d err=%b expected %h 5 0", o_rd, o_lat, o_err, exp);
    end
  endtask

  task automatic test_random();
    int inst, exp_lat;
    logic wen, uns, err;
    logic [1:0] size;
    logic [31:0] a, wd, exp_rd;
    for (int n = 0; n < 60; n++) begin
      inst = ($urandom_range(0, 3) == 0) ? 3 : 1;
      wen = 1'($urandom); uns = 1'($urandom);
      size = 2'($urandom_range(0, 3));
      a = $urandom; wd = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (size == 2'b01) a[0] = 1'b0;
        if (size == 2'b10) a[1:0] = 2'b00;
      end
      err = exp_err(size, a);
      exp_lat = err ? 1 : (wen ? 2 : 2 + ((inst == 3) ? 3 : 1));
      exp_rd = (err || wen) ? 32'h0 : ref_load(inst, size, uns, a);
      run_txn(inst, wen, size, uns, a, wd);
      if (!err && wen) ref_store(inst, size, a, wd);
      checks++;
      if (o_err !== err || o_lat !== exp_lat || o_rd !== exp_rd || o_pulses !== 1) begin
        errors++; $display("FAIL rand_rsp n=%0d inst=%0d wen=%b size=%b addr=%h err=%b lat=%0d rd=%h pulses=%0d expected %b %0d %h 1",
                           n, inst, wen, size, a, o_err, o_lat, o_rd, o_pulses, err, exp_lat, exp_rd);
      end
      checks++;
      if (o_nreq !== (err ? 0 : 1) ||
          (!err && (o_wen !== wen || o_mode !== size || o_addr !== a || o_dat !== exp_bus_dat(wen, size, a, wd)))) begin
        errors++; $display("FAIL rand_bus n=%0d nreq=%0d wen=%b mode=%b addr=%h dat=%h expected %0d %b %b %h %h",
                           n, o_nreq, o_wen, o_mode, o_addr, o_dat, err ? 0 : 1, wen, size, a,
                           exp_bus_dat(wen, size, a, wd));
      end
      checks++;
      if (o_busy_ready !== 1'b0 || o_rdy_after !== 1'b1 || o_clear_after !== 1'b1) begin
        errors++; $display("FAIL rand_ready n=%0d busy_ready=%b ready_after=%b cleared=%b expected 0 1 1",
                           n, o_busy_ready, o_rdy_after, o_clear_after);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      poke(1, 32'(i * 4), $urandom);
      poke(3, 32'(i * 4), $urandom);
    end
    test_reset();
    test_word_store_load();
    test_byte_loads();
    test_half_store();
    test_misaligned();
    test_rdlat3();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
